// File: rtl/lcd_power_sequencer.sv
// rtl/lcd_power_sequencer.sv - LVDS LCD panel power sequencer with backlight PWM
// Orders VDD -> LVDS/video -> backlight on enable and unwinds in reverse on disable or lock loss.
module lcd_power_sequencer #(
  parameter int TICK_DIV   = 72000,
  parameter int T_VDD_LINK = 20,
  parameter int T_LINK_BL  = 200,
  parameter int T_BL_LINK  = 200,
  parameter int T_LINK_VDD = 20,
  parameter int T_OFF_MIN  = 500,
  parameter int PWM_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       mmcm_lckd,
  input  logic [7:0] brightness,
  output logic       panel_vdd_en,
  output logic       lvds_en,
  output logic       video_en,
  output logic       bl_en,
  output logic       bl_pwm,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam int T_MAX_A = (T_VDD_LINK > T_LINK_BL) ? T_VDD_LINK : T_LINK_BL;
  localparam int T_MAX_B = (T_BL_LINK > T_LINK_VDD) ? T_BL_LINK : T_LINK_VDD;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int OFF_CYC = T_OFF_MIN * TICK_DIV;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW      = $clog2(T_MAX + 1);
  localparam int OW      = (OFF_CYC > 1) ? $clog2(OFF_CYC) : 1;
  localparam int DW      = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR     = 3'd1,
    S_LINK    = 3'd2,
    S_ON      = 3'd3,
    S_BLOFF   = 3'd4,
    S_LINKOFF = 3'd5
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   ticks;
  logic [TW-1:0]   dwell;
  logic [OW-1:0]   off_cnt;
  logic            timed;
  logic            presc_last;
  logic            dwell_done;
  logic            off_done;
  logic            abort;

  logic [DW-1:0]   pwm_pre;
  logic [7:0]      pwm_cnt;
  logic [7:0]      duty;
  logic            pwm_step;
  logic [7:0]      cnt_nx;
  logic [7:0]      duty_nx;

  always_comb begin
    dwell = '0;
    case (cur)
      S_PWR:     dwell = TW'(T_VDD_LINK);
      S_LINK:    dwell = TW'(T_LINK_BL);
      S_BLOFF:   dwell = TW'(T_BL_LINK);
      S_LINKOFF: dwell = TW'(T_LINK_VDD);
      default:   dwell = '0;
    endcase
  end

  assign timed      = (cur != S_OFF) && (cur != S_ON);
  assign presc_last = (presc == PW'(TICK_DIV - 1));
  assign dwell_done = timed && presc_last && (ticks == dwell - TW'(1));
  assign off_done   = (off_cnt == OW'(OFF_CYC - 1));
  assign abort      = !enable || !mmcm_lckd;

  always_comb begin
    nxt          = cur;
    panel_vdd_en = 1'b0;
    lvds_en      = 1'b0;
    bl_en        = 1'b0;
    case (cur)
      S_OFF: begin
        if (enable && mmcm_lckd && !fault && off_done) nxt = S_PWR;
      end
      S_PWR: begin
        panel_vdd_en = 1'b1;
        if (abort)           nxt = S_LINKOFF;
        else if (dwell_done) nxt = S_LINK;
      end
      S_LINK: begin
        panel_vdd_en = 1'b1;
        lvds_en      = 1'b1;
        if (abort)           nxt = S_BLOFF;
        else if (dwell_done) nxt = S_ON;
      end
      S_ON: begin
        panel_vdd_en = 1'b1;
        lvds_en      = 1'b1;
        bl_en        = 1'b1;
        if (abort) nxt = S_BLOFF;
      end
      // Shutdown states always run to completion regardless of enable/lock.
      S_BLOFF: begin
        panel_vdd_en = 1'b1;
        lvds_en      = 1'b1;
        if (dwell_done) nxt = S_LINKOFF;
      end
      S_LINKOFF: begin
        panel_vdd_en = 1'b1;
        if (dwell_done) nxt = S_OFF;
      end
      default: nxt = S_OFF;
    endcase
  end

  assign video_en = lvds_en;
  assign ready    = (cur == S_ON);
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_OFF;
      presc   <= '0;
      ticks   <= '0;
      off_cnt <= OW'(OFF_CYC - 1);
      fault   <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur) begin
        presc <= '0;
        ticks <= '0;
      end else if (timed) begin
        if (presc_last) begin
          presc <= '0;
          ticks <= ticks + TW'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (cur != S_OFF && nxt == S_OFF) off_cnt <= '0;
      else if (cur == S_OFF && !off_done) off_cnt <= off_cnt + OW'(1);
      if (cur != S_OFF && !mmcm_lckd) fault <= 1'b1;
      else if (cur == S_OFF && !enable) fault <= 1'b0;
    end
  end

  assign pwm_step = (pwm_pre == DW'(PWM_DIV - 1));
  assign cnt_nx   = pwm_step ? pwm_cnt + 8'd1 : pwm_cnt;
  assign duty_nx  = (pwm_step && pwm_cnt == 8'hFF) ? brightness : duty;

  // bl_pwm is built from next-cycle values so it can never lead or trail bl_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_pre <= '0;
      pwm_cnt <= '0;
      duty    <= '0;
      bl_pwm  <= 1'b0;
    end else begin
      pwm_pre <= pwm_step ? '0 : pwm_pre + DW'(1);
      pwm_cnt <= cnt_nx;
      duty    <= duty_nx;
      bl_pwm  <= (nxt == S_ON) && ((duty_nx == 8'hFF) || (cnt_nx < duty_nx));
    end
  end

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// tb/tb_lcd_power_sequencer.sv - scoreboard bench for lcd_power_sequencer
// Reference model tracks phase, remaining dwell and off-window age; monitor compares every cycle.
module tb_lcd_power_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int T_VDD_LINK = 2;
  localparam int T_LINK_BL  = 3;
  localparam int T_BL_LINK  = 3;
  localparam int T_LINK_VDD = 2;
  localparam int T_OFF_MIN  = 5;
  localparam int PWM_DIV    = 1;
  localparam int OFF_CYC    = T_OFF_MIN * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       mmcm_lckd = 1'b1;
  logic [7:0] brightness = 8'd0;
  logic       panel_vdd_en, lvds_en, video_en, bl_en, bl_pwm, ready, fault;
  logic [2:0] state;

  lcd_power_sequencer #(
    .TICK_DIV(TICK_DIV), .T_VDD_LINK(T_VDD_LINK), .T_LINK_BL(T_LINK_BL),
    .T_BL_LINK(T_BL_LINK), .T_LINK_VDD(T_LINK_VDD), .T_OFF_MIN(T_OFF_MIN), .PWM_DIV(PWM_DIV)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mmcm_lckd(mmcm_lckd), .brightness(brightness),
    .panel_vdd_en(panel_vdd_en), .lvds_en(lvds_en), .video_en(video_en), .bl_en(bl_en),
    .bl_pwm(bl_pwm), .ready(ready), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic vdd, lvds, video, bl, pwm, rdy, flt;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int   m_phase, m_left, m_off_age, m_n, m_cnt;
  logic m_fault, m_nf, m_abort;
  logic [7:0] m_duty;
  obs_t m_exp;

  function automatic int dwell_of(input int p);
    case (p)
      1: return T_VDD_LINK * TICK_DIV;
      2: return T_LINK_BL * TICK_DIV;
      4: return T_BL_LINK * TICK_DIV;
      5: return T_LINK_VDD * TICK_DIV;
      default: return 0;
    endcase
  endfunction

  task automatic enter(input int p);
    m_phase = p;
    m_left  = dwell_of(p);
    if (p == 0) m_off_age = 1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_off_age = OFF_CYC; m_fault = 1'b0; m_n = 0; m_duty = 8'd0;
    end else begin
      m_abort = !enable || !mmcm_lckd;
      m_nf = m_fault;
      if (m_phase != 0 && !mmcm_lckd) m_nf = 1'b1;
      else if (m_phase == 0 && !enable) m_nf = 1'b0;
      case (m_phase)
        0: if (enable && mmcm_lckd && !m_fault && m_off_age >= OFF_CYC) enter(1);
           else if (m_off_age < OFF_CYC) m_off_age++;
        1: if (m_abort) enter(5); else if (m_left == 1) enter(2); else m_left--;
        2: if (m_abort) enter(4); else if (m_left == 1) enter(3); else m_left--;
        3: if (m_abort) enter(4);
        4: if (m_left == 1) enter(5); else m_left--;
        default: if (m_left == 1) enter(0); else m_left--;
      endcase
      m_fault = m_nf;
      m_n++;
      if (m_n % (256 * PWM_DIV) == 0) m_duty = brightness;
    end
    m_cnt     = (m_n / PWM_DIV) % 256;
    m_exp.st  = 3'(m_phase);
    m_exp.vdd = (m_phase != 0);
    m_exp.lvds = (m_phase == 2) || (m_phase == 3) || (m_phase == 4);
    m_exp.video = m_exp.lvds;
    m_exp.bl  = (m_phase == 3);
    m_exp.rdy = (m_phase == 3);
    m_exp.flt = m_fault;
    m_exp.pwm = m_exp.bl && ((m_duty == 8'hFF) || (m_cnt < int'(m_duty)));
    exp_q.push_back(m_exp);
  end

  obs_t mon_e, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {state, panel_vdd_en, lvds_en, video_en, bl_en, bl_pwm, ready, fault};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got st=%0d v/l/vid/bl/pwm/rdy/flt=%b required st=%0d %b",
                 $time, mon_a.st, mon_a[6:0], mon_e.st, mon_e[6:0]);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0: return panel_vdd_en;
      1: return lvds_en;
      2: return bl_en;
      3: return ready;
      default: return fault;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int limit, output int c);
    c = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (probe(sel) == val) begin c = i; break; end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int c);
    c = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (state == s) begin c = i; break; end
    end
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bl_pwm) h++;
    end
  endtask

  function automatic int outs();
    return int'({panel_vdd_en, lvds_en, video_en, bl_en, bl_pwm, ready, fault});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t, h;
    repeat (3) @(posedge clk); #1;
    check("reset_state", int'(state), 0);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    enable = 1'b1;
    wait_sig(0, 1'b1, 50, c); t = c;     check("up_vdd", t, 1);
    wait_sig(1, 1'b1, 50, c); t = t + c; check("up_lvds", t, 9);
    check("up_video", int'(video_en), 1);
    wait_sig(2, 1'b1, 50, c); t = t + c; check("up_bl", t, 21);
    check("up_ready", int'(ready), 1);

    enable = 1'b0;
    wait_sig(2, 1'b0, 50, c); check("down_bl", c, 1);
    check("down_ready", int'(ready), 0);
    wait_sig(1, 1'b0, 50, c); check("down_lvds", c, 12);
    wait_sig(0, 1'b0, 50, c); check("down_vdd", c, 8);
    check("down_state", int'(state), 0);

    repeat (4) @(posedge clk); #1;
    enable = 1'b1;
    wait_state(3'd1, 60, c); check("offwin_reentry", 4 + c, 20);
    wait_sig(3, 1'b1, 60, c); check("reup_ready", c, 20);

    brightness = 8'd64;  repeat (300) @(posedge clk); count_high(256, h); check("pwm_64", h, 64);
    brightness = 8'd255; repeat (300) @(posedge clk); count_high(256, h); check("pwm_255", h, 256);
    brightness = 8'd0;   repeat (300) @(posedge clk); count_high(256, h); check("pwm_0", h, 0);

    brightness = 8'd255;
    repeat (300) @(posedge clk); #1;
    check("pre_rst_pwm", int'(bl_pwm), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_on_state", int'(state), 0);
    check("rst_on_outputs", outs(), 0);
    rst = 1'b0;
    wait_state(3'd1, 10, c); check("rst_offtimer_expired", c, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_pwr_state", int'(state), 0);
    check("rst_pwr_outputs", outs(), 0);
    rst = 1'b0;

    wait_state(3'd2, 30, c); check("to_link", c, 9);
    mmcm_lckd = 1'b0;
    @(posedge clk); #1;
    check("lock_fault", int'(fault), 1);
    check("lock_blank", int'(state), 4);
    mmcm_lckd = 1'b1;
    wait_state(3'd0, 60, c); check("lock_to_off", c, 20);
    repeat (40) @(posedge clk); #1;
    check("fault_holds_off", int'(state), 0);
    check("fault_sticky", int'(fault), 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("fault_clear", int'(fault), 0);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(1999) == 0);
      if ($urandom_range(59) == 0) enable = ~enable;
      if (mmcm_lckd) begin
        if ($urandom_range(299) == 0) mmcm_lckd = 1'b0;
      end else if ($urandom_range(4) == 0) begin
        mmcm_lckd = 1'b1;
      end
      if ($urandom_range(79) == 0) brightness = 8'($urandom);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
